if_id_hazard: RTL
=================

IF_ID_HAZARD -- requirements
Module: if_id_hazard

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL provide port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL provide port rst, input, 1 bit: asynchronous reset, active-low.
REQ-004 The block SHALL provide port pc_in, input, 64 bits: PC of the fetched instruction.
REQ-005 The block SHALL provide port instr_in, input, 32 bits: fetched instruction word.
REQ-006 The block SHALL provide port if_valid_in, input, 1 bit: fetch output valid.
REQ-007 The block SHALL provide port idex_memread_in, input, 1 bit: ID/EX MemRead_out.
REQ-008 The block SHALL provide port idex_rd_in, input, 5 bits: ID/EX rd_out.
REQ-009 The block SHALL provide port branch_taken_in, input, 1 bit: EX branch/jump redirect.
REQ-010 The block SHALL provide port pc_out, output, 64 bits: registered PC.
REQ-011 The block SHALL provide port instr_out, output, 32 bits: registered instruction.
REQ-012 The block SHALL provide port valid_out, output, 1 bit: registered instruction is live.
REQ-013 The block SHALL provide ports rs1_out, rs2_out and rd_out, outputs, 5 bits each: instr_out[19:15], [24:20] and [11:7].
REQ-014 The block SHALL provide port pc_write_out, output, 1 bit: 0 = PC holds.
REQ-015 The block SHALL provide port ctrl_zero_out, output, 1 bit: 1 = ID/EX control inputs forced to 0 (bubble).
REQ-016 The block SHALL provide port stall_cnt_out, output, 16 bits, only under IF_ID_STALL_CNT_EN: load-use stall count.

Function
REQ-017 The block SHALL compute combinationally: hazard = valid_out & idex_memread_in & (idex_rd_in != 0) & (idex_rd_in == rs1_out | idex_rd_in == rs2_out).
REQ-018 The block SHALL drive pc_write_out = ~hazard | branch_taken_in.
REQ-019 The block SHALL drive ctrl_zero_out = hazard | ~valid_out | branch_taken_in.
REQ-020 The block SHALL implement a 2-bit state register with states RUN, STALL and FLUSH.
REQ-021 In RUN with no hazard and no branch, the block SHALL, at the next edge, load pc_in into pc_out and instr_in into instr_out, load if_valid_in into valid_out, and stay in RUN (one-cycle latency).
REQ-022 In RUN with hazard and no branch, the block SHALL hold pc_out, instr_out and valid_out and go to STALL.
REQ-023 In STALL, the block SHALL load normally (as REQ-021) and return to RUN; the bubble has cleared idex_memread_in, so STALL lasts exactly one cycle.
REQ-024 If branch_taken_in = 1 in any state, the block SHALL load instr_out = 0x00000013 (NOP), valid_out = 0 and pc_out = 0, and go to FLUSH; branch SHALL take priority over hazard.
REQ-025 In FLUSH with no new branch, the block SHALL load NOP with valid_out = 0 one more cycle, discarding the in-flight wrong-path fetch, then go to RUN.
REQ-026 A branch arriving in FLUSH SHALL restart FLUSH for one further cycle.
REQ-027 If if_valid_in = 0 during a normal load, the block SHALL load instr_out = NOP, valid_out = 0 and pc_out = pc_in.

Reset
REQ-028 While rst = 0, asynchronously: pc_out = 0, instr_out = 0x00000013, valid_out = 0, state = RUN, and stall counter = 0.
REQ-029 As a consequence of reset, pc_write_out SHALL be 1 and ctrl_zero_out SHALL be 1.
REQ-030 Reset asserted mid-STALL or mid-FLUSH SHALL abort that state, with no residual hold or flush after release.
REQ-031 The first load SHALL occur on the first rising edge with rst = 1.

Configuration
REQ-032 With IF_ID_STALL_CNT_EN defined, the block SHALL provide a 16-bit counter stall_cnt_out that increments on each edge where hazard = 1 and branch_taken_in = 0, and saturates at 0xFFFF.
REQ-033 With IF_ID_STALL_CNT_EN undefined, the stall_cnt_out port and its counter logic SHALL be absent, with the rest of the behaviour unchanged.

Verification
REQ-034 Reset with pc_in = 0x100, instr_in = 0x00A00093 -> outputs at reset values; first edge after release -> pc_out = 0x100, rs1_out = 0, rd_out = 1, valid_out = 1.
REQ-035 instr_out = 0x00208133 (rs1 = 1, rs2 = 2) valid, idex_memread_in = 1, idex_rd_in = 2 -> hazard, pc_write_out = 0, ctrl_zero_out = 1, outputs held one edge, then next load; stall_cnt_out = 1 when enabled.
REQ-036 Same as REQ-035 with idex_rd_in = 0, or with idex_memread_in = 0 -> no stall, pc_write_out = 1.
REQ-037 branch_taken_in pulse for one cycle -> instr_out = 0x00000013 and valid_out = 0 for two edges, then a normal load in the third cycle.
REQ-038 Hazard and branch in the same cycle -> FLUSH taken, pc_write_out = 1, no stall count.
REQ-039 rst asserted during STALL -> immediate reset values; after release, a normal load with no extra hold.

Source files
------------

// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use stall and branch-flush control.
// Optional load-use stall counter is enabled by defining IF_ID_STALL_CNT_EN.
module if_id_hazard (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        if_valid_in,
  input  logic        idex_memread_in,
  input  logic [4:0]  idex_rd_in,
  input  logic        branch_taken_in,
  output logic [63:0] pc_out,
  output logic [31:0] instr_out,
  output logic        valid_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [4:0]  rd_out,
  output logic        pc_write_out,
  output logic        ctrl_zero_out
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt_out
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        hazard;

  assign rs1_out   = instr_q[19:15];
  assign rs2_out   = instr_q[24:20];
  assign rd_out    = instr_q[11:7];
  assign pc_out    = pc_q;
  assign instr_out = instr_q;
  assign valid_out = valid_q;

  // Load-use: the load in EX writes a register the instruction held here reads.
  assign hazard = valid_q & idex_memread_in & (idex_rd_in != 5'd0) &
                  ((idex_rd_in == rs1_out) | (idex_rd_in == rs2_out));

  assign pc_write_out  = ~hazard | branch_taken_in;
  assign ctrl_zero_out = hazard | ~valid_q | branch_taken_in;

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;

    if (branch_taken_in) begin
      pc_d    = 64'd0;
      instr_d = NOP;
      valid_d = 1'b0;
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        RUN: begin
          if (hazard) begin
            state_d = STALL;
          end else begin
            pc_d    = pc_in;
            instr_d = if_valid_in ? instr_in : NOP;
            valid_d = if_valid_in;
            state_d = RUN;
          end
        end
        FLUSH: begin
          // Second bubble drops the wrong-path fetch already in flight.
          pc_d    = 64'd0;
          instr_d = NOP;
          valid_d = 1'b0;
          state_d = RUN;
        end
        default: begin
          // STALL (and the unused encoding) always load: the bubble has cleared the hazard.
          pc_d    = pc_in;
          instr_d = if_valid_in ? instr_in : NOP;
          valid_d = if_valid_in;
          state_d = RUN;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= 64'd0;
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

`ifdef IF_ID_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && !branch_taken_in && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
`endif

endmodule
